// File: rtl/wb_pkg.sv
// Shared load-size encoding for the write-back stage.
package wb_pkg;

  typedef logic [1:0] ld_size_t;

  localparam ld_size_t LD_BYTE = 2'b00;
  localparam ld_size_t LD_HALF = 2'b01;
  localparam ld_size_t LD_WORD = 2'b10;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-WB bus: instruction fields from the MEM stage and the register-file write port.
interface wb_stage_pipe_if
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // Handshake: a transfer happens on a rising edge where in_valid and in_ready are
  // both 1; the master keeps in_valid and every field stable until that edge.
  logic              in_valid;
  logic              in_ready;
  logic              mem_to_reg;
  logic              reg_write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] dir;
  ld_size_t          ld_size;
  logic              ld_signed;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] data_out;

  modport master (
    output in_valid, mem_to_reg, reg_write, rd, data_in, dir, ld_size, ld_signed,
    input  in_ready, wb_en, wb_addr, data_out
  );

  modport slave (
    input  in_valid, mem_to_reg, reg_write, rd, data_in, dir, ld_size, ld_signed,
    output in_ready, wb_en, wb_addr, data_out
  );

endinterface

// File: rtl/wb_load_ext.sv
// Combinational byte/halfword lane extraction with zero or sign extension.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  ld_size_t          ld_size,
  input  logic              ld_signed,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    // lane[0] plays no part for halves, so odd addresses never trap
    half_sel = lane[1] ? word[31:16] : word[15:0];

    result = word;
    case (ld_size)
      LD_BYTE: result = {{(DATA_W-8){ld_signed & byte_sel[7]}}, byte_sel};
      LD_HALF: result = {{(DATA_W-16){ld_signed & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: one-entry pipe with stall/flush and a retired counter.
// Optional narrow-load extraction is built when WB_LOAD_EXT_EN is defined.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  wb_stage_pipe_if.slave       bus,
  output logic [CNT_W-1:0]     retired
);

  logic              valid_q;
  logic              rw_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] wr_data;
  logic              in_ready;
  logic              complete;

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .word      (bus.data_in),
    .lane      (bus.dir[1:0]),
    .ld_size   (bus.ld_size),
    .ld_signed (bus.ld_signed),
    .result    (mem_word)
  );
`else
  logic unused_ld;
  assign unused_ld = ^{bus.ld_size, bus.ld_signed};
  assign mem_word  = bus.data_in;
`endif

  assign wr_data  = bus.mem_to_reg ? mem_word : bus.dir;
  assign in_ready = !valid_q || !stall;
  // A flushed entry leaves without being counted
  assign complete = valid_q && !stall && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      wb_addr_q <= '0;
      data_q    <= '0;
      retired   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          rw_q      <= bus.reg_write;
          wb_addr_q <= bus.rd;
          data_q    <= wr_data;
        end
      end
      if (complete) begin
        retired <= retired + 1'b1;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wb_en    = valid_q && rw_q && (wb_addr_q != '0);
  assign bus.wb_addr  = wb_addr_q;
  assign bus.data_out = data_q;

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised, registered write-back stage that sits between the MEM stage and the register-file write port. Selects memory read data (`data_in`) or ALU result/address (`dir`) under `mem_to_reg`, as the existing combinational write-back mux does. Adds:
- a one-entry pipeline register with valid/ready, stall and flush;
- byte/halfword load extraction with sign/zero extension;
- a retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 32: datapath width; must be a multiple of 16, ≥32.
- `ADDR_W`, 5: register index width.
- `CNT_W`, 32: retired-counter width.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  MEM stage presents an instruction
- `in_ready`  out  1  stage accepts this cycle
- `stall`  in  1  downstream hold; freezes the held entry
- `flush`  in  1  kill held entry and block capture
- `mem_to_reg`  in  1  1 = write memory data, 0 = write `dir`
- `reg_write`  in  1  instruction writes a register
- `rd`  in  ADDR_W  destination register
- `data_in`  in  DATA_W  memory read word
- `dir`  in  DATA_W  ALU result / load address
- `ld_size`  in  2  00 byte, 01 half, 10/11 word
- `ld_signed`  in  1  sign-extend narrow loads
- `wb_en`  out  1  register-file write enable
- `wb_addr`  out  ADDR_W  register-file write address
- `data_out`  out  DATA_W  register-file write data
- `retired`  out  CNT_W  count of completed instructions

## Operation
- State: `valid_q`, `rw_q`, `wb_addr`, `data_out`, `retired`.
- `in_ready = !valid_q || !stall` (combinational). Capture when `in_valid && in_ready && !flush`: `valid_q` ← 1, all fields registered.
- `in_ready && !in_valid` (or `flush`): `valid_q` ← 0.
- Stall with `valid_q = 1`: every register holds.
- Flush: `valid_q` ← 0 next edge, overriding stall and capture. The held entry is not counted.
- Write data, computed before the register:
  - `mem_to_reg = 0` → `dir`.
  - `mem_to_reg = 1` → extract(`data_in`).
- Extraction (with `WB_LOAD_EXT_EN`):
  - Byte: lane `dir[1:0]`, bits `[8k+7:8k]`.
  - Half: lane `dir[1]`, bits `[16k+15:16k]`; `dir[0]` is ignored, so there is no misalignment trap.
  - Word: unchanged.
  - Narrow results are zero-extended, or sign-extended when `ld_signed` is 1.
- `wb_en = valid_q && rw_q && (wb_addr != 0)`. Register 0 is never written, but a write to r0 still counts as retired.
- Completion: `valid_q && !stall && !flush` → `retired` +1. It wraps from all-ones to 0.

## Timing
- Reset (async assert): `valid_q`, `wb_en`, `wb_addr`, `data_out`, `retired` = 0; `in_ready` = 1. Release is synchronous to `clk`.
- Reset mid-operation drops the held entry with no write and no count.
- Latency: data captured at edge N appears on `data_out`/`wb_en` after edge N; the register-file write lands at edge N+1.
- Throughput: 1 instruction/cycle with `stall = 0`.
- While stalled, `wb_en` stays asserted; the repeated identical write is harmless. The counter does not advance.
- Stall and a new `in_valid` together with `valid_q = 1`: `in_ready = 0`, so there is no capture and the upstream holds.
- Stall and flush together: flush wins.

## Configuration
- `WB_LOAD_EXT_EN` defined: byte/halfword extraction and extension as above.
- Undefined: `ld_size` and `ld_signed` are ignored; memory data passes as the full word and the extractor is not instantiated.

## Structure
- Package `wb_pkg`:
  - Constants `LD_BYTE = 2'b00`, `LD_HALF = 2'b01`, `LD_WORD = 2'b10`.
  - Typedef `ld_size_t`.
- Sub-module `wb_load_ext`: combinational extractor. Inputs: word, `dir[1:0]`, `ld_size`, `ld_signed`. Output: `DATA_W` result.
- Top module: pipeline register, handshake, counter.

## Test plan
- Reset: hold `rst` = 0 mid-stream → all outputs 0, `in_ready` = 1. Release, then push one ALU op (`rd` = 3, `dir` = 1) → next cycle `wb_en` = 1, `wb_addr` = 3, `data_out` = 1, `retired` = 1.
- Load word: `data_in` = 0xAAAAAAAA, `mem_to_reg` = 1, `ld_size` = 10 → `data_out` = 0xAAAAAAAA. The same push with `mem_to_reg` = 0, `dir` = 0xFFFFFFFF → `data_out` = 0xFFFFFFFF.
- Extension (`WB_LOAD_EXT_EN`): `data_in` = 0x0000FF80.
  - Signed byte, `dir` = 0 → 0xFFFFFF80.
  - Unsigned byte, `dir` = 1 → 0x000000FF.
  - Signed half, `dir` = 2 → 0x00000000.
  - Signed half, `dir` = 0 → 0xFFFFFF80.
- Stall: assert `stall` 3 cycles with an entry held → `in_ready` = 0, outputs frozen, `retired` unchanged. Release → count +1, next entry accepted.
- Flush/r0: flush a held entry → `wb_en` = 0 next cycle, no count. An entry with `rd` = 0, `reg_write` = 1 → `wb_en` = 0 and `retired` +1.
- Wrap: `CNT_W` = 4, retire 17 instructions → `retired` = 1.
